ipsxe_floating_point_abcop_sched_v1_0: RTL and testbench
========================================================

Name: ipsxe_floating_point_abcop_sched_v1_0

Overview:
- Input-side scheduler for the a/b/c/operation floating-point datapath.
- Each AXI4-Stream input channel gets its own 1-entry holding register and tready. The block issues one combined operand beat to the core only when all four channels hold data and a result credit is available.
- Tracks outstanding results against a downstream result-buffer depth, and supports a flush/drain sequence.

Parameters:
- DATA_WIDTH, 32, width of each of the a/b/c operand channels.
- OP_WIDTH, 8, width of the operation channel tdata.
- CREDITS, 16, downstream result-buffer depth = maximum outstanding issued operations (range 1..255).

Ports:
- i_aclk  in  1  clock; all logic is on the rising edge.
- i_areset  in  1  synchronous, active-high reset.
- i_axi4s_a_tvalid / i_axi4s_a_tdata / i_axi4s_a_tlast  in  1/DATA_WIDTH/1  channel a slave.
- o_axi4s_a_tready  out  1  channel a ready.
- i_axi4s_b_*, o_axi4s_b_tready  same as a  channel b.
- i_axi4s_c_*, o_axi4s_c_tready  same as a  channel c.
- i_axi4s_operation_tvalid / _tdata / _tlast  in  1/OP_WIDTH/1  operation channel.
- o_axi4s_operation_tready  out  1  operation channel ready.
- o_core_valid  out  1  one-cycle issue strobe to the datapath.
- o_core_a, o_core_b, o_core_c  out  DATA_WIDTH each  issued operands.
- o_core_op  out  OP_WIDTH  issued operation.
- o_core_last  out  1  issued tlast (channel a tlast).
- i_credit_return  in  1  pulse: downstream consumed one result.
- i_flush  in  1  pulse: request drain.
- o_flush_done  out  1  one-cycle pulse when drain completes.
- o_outstanding  out  8  current issued-but-unreturned count.

Behaviour:
- Reset (i_areset=1 at the clock edge):
  - all holding registers empty, all tready=0 during reset, o_core_valid=0, core data outputs 0;
  - o_outstanding=0, o_flush_done=0, state=RUN.
- Per channel:
  - tready = holding register empty AND state==RUN.
  - A transfer (tvalid & tready) loads the register and sets full.
  - A full register is held until issue; there is no overwrite.
- Issue condition: state==RUN AND all four registers full AND o_outstanding<CREDITS.
- On issue:
  - next cycle o_core_valid=1 with the registered data; all four registers clear together;
  - o_outstanding increments.
  - Latency: the last arriving channel's accept edge to o_core_valid = 1 cycle when credit is available.
- tready is not combinationally re-asserted in the issue cycle. The next accept happens at the earliest 1 cycle after issue, so peak throughput is 1 issue per 2 cycles.
- o_core_valid is high for exactly one cycle per issue. Data outputs hold their last values otherwise.
- Credits:
  - i_credit_return decrements o_outstanding.
  - Issue and return in the same cycle leave the count unchanged.
  - A return at o_outstanding=0 is ignored (saturate at 0).
- Credit exhausted (o_outstanding==CREDITS): full registers are held, and tready stays 0 for full channels.
- State machine:
  - RUN -> DRAIN on i_flush: all holding registers are cleared (held beats discarded) and tready=0.
  - DRAIN -> DONE when o_outstanding==0 (credit returns continue to be counted).
  - DONE -> RUN after one cycle; o_flush_done=1 during the DONE cycle.
  - i_flush while in DRAIN/DONE is ignored.
  - i_flush in the same cycle as an issue condition: the flush wins and no issue occurs.
- Reset mid-DRAIN returns to RUN with o_outstanding=0 immediately.
- o_outstanding width is 8 bits. CREDITS>255 is unsupported.

Optional Feature:
- Macro IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN.
- When defined:
  - Adds output o_last_mismatch (1 bit, sticky).
  - It sets on any issue where the four held tlast bits are not all equal, and clears only on i_areset.
  - o_core_last remains channel a tlast.
- When undefined: the port does not exist, tlast of b/c/operation is ignored, and no extra logic is built.

Test Plan:
- Staggered arrival:
  - Stimulus: a at cycle 0, b at 3, c at 5, op at 7, CREDITS=16.
  - Required response: o_core_valid=1 at cycle 8 only; tready for a stays 0 during cycles 1..7; o_outstanding=1.
- Back-to-back:
  - Stimulus: all four channels tvalid continuously for 20 cycles, no credit returns, CREDITS=4.
  - Required response: exactly 4 issues spaced 2 cycles apart; then all tready stay 0 with the registers held; o_outstanding=4.
- Credit exhaustion recovery:
  - Stimulus: from the back-to-back end state, one i_credit_return pulse.
  - Required response: o_outstanding 4->3, then the held beat issues the next cycle, giving o_outstanding=4.
- Simultaneous issue and return:
  - Stimulus: o_outstanding=2, issue condition and i_credit_return in the same cycle.
  - Required response: o_outstanding stays 2; o_core_valid pulses once.
- Flush:
  - Stimulus: outstanding=3 with a and b held, then i_flush, then 3 returns.
  - Required response: registers cleared; tready=0 throughout DRAIN; o_flush_done pulses 1 cycle after the count reaches 0; then RUN resumes with tready=1.
- Last check (macro defined):
  - Stimulus: issue with a_tlast=1 and b_tlast=0, then an issue with all tlast bits matching.
  - Required response: o_last_mismatch=1 from the first issue onward and stays 1 until i_areset.

Source files
------------

// File: rtl/ipsxe_floating_point_abcop_sched_v1_0.sv
// Input-side a/b/c/op scheduler: per-channel 1-entry holding, credit-gated issue, flush/drain.
// Optional: `define IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN adds sticky o_last_mismatch.
module ipsxe_floating_point_abcop_sched_v1_0 #(
   parameter int DATA_WIDTH = 32,
   parameter int OP_WIDTH   = 8,
   parameter int CREDITS    = 16
) (
   input  logic                  i_aclk,
   input  logic                  i_areset,
   input  logic                  i_axi4s_a_tvalid,
   input  logic [DATA_WIDTH-1:0] i_axi4s_a_tdata,
   input  logic                  i_axi4s_a_tlast,
   output logic                  o_axi4s_a_tready,
   input  logic                  i_axi4s_b_tvalid,
   input  logic [DATA_WIDTH-1:0] i_axi4s_b_tdata,
   input  logic                  i_axi4s_b_tlast,
   output logic                  o_axi4s_b_tready,
   input  logic                  i_axi4s_c_tvalid,
   input  logic [DATA_WIDTH-1:0] i_axi4s_c_tdata,
   input  logic                  i_axi4s_c_tlast,
   output logic                  o_axi4s_c_tready,
   input  logic                  i_axi4s_operation_tvalid,
   input  logic [OP_WIDTH-1:0]   i_axi4s_operation_tdata,
   input  logic                  i_axi4s_operation_tlast,
   output logic                  o_axi4s_operation_tready,
   output logic                  o_core_valid,
   output logic [DATA_WIDTH-1:0] o_core_a,
   output logic [DATA_WIDTH-1:0] o_core_b,
   output logic [DATA_WIDTH-1:0] o_core_c,
   output logic [OP_WIDTH-1:0]   o_core_op,
   output logic                  o_core_last,
   input  logic                  i_credit_return,
   input  logic                  i_flush,
   output logic                  o_flush_done,
   output logic [7:0]            o_outstanding
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
   ,
   output logic                  o_last_mismatch
`endif
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [7:0] CRED = CREDITS[7:0];

   state_t state_q;

   logic [DATA_WIDTH-1:0] a_q, b_q, c_q;
   logic [OP_WIDTH-1:0]   op_q;
   logic                  a_last_q;
   logic                  full_a, full_b, full_c, full_op;

   logic run, all_full, credit_ok, issue, ret;
   logic acc_a, acc_b, acc_c, acc_op;

`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
   logic b_last_q, c_last_q, op_last_q;
   logic last_diff;
`else
   logic unused_tlast;
   assign unused_tlast = ^{i_axi4s_b_tlast, i_axi4s_c_tlast,
                           i_axi4s_operation_tlast};
`endif

   always_comb begin
      run       = (state_q == RUN) && !i_areset;
      o_axi4s_a_tready         = run && !full_a;
      o_axi4s_b_tready         = run && !full_b;
      o_axi4s_c_tready         = run && !full_c;
      o_axi4s_operation_tready = run && !full_op;
      acc_a     = i_axi4s_a_tvalid && o_axi4s_a_tready;
      acc_b     = i_axi4s_b_tvalid && o_axi4s_b_tready;
      acc_c     = i_axi4s_c_tvalid && o_axi4s_c_tready;
      acc_op    = i_axi4s_operation_tvalid && o_axi4s_operation_tready;
      all_full  = full_a && full_b && full_c && full_op;
      credit_ok = o_outstanding < CRED;
      // A flush in the same cycle suppresses the issue.
      issue     = run && all_full && credit_ok && !i_flush;
      ret       = i_credit_return && (o_outstanding != 8'd0);
   end

`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
   assign last_diff = !((a_last_q == b_last_q) && (a_last_q == c_last_q) &&
                        (a_last_q == op_last_q));
`endif

   always_ff @(posedge i_aclk) begin
      if (i_areset) begin
         state_q       <= RUN;
         a_q           <= '0;
         b_q           <= '0;
         c_q           <= '0;
         op_q          <= '0;
         a_last_q      <= 1'b0;
         full_a        <= 1'b0;
         full_b        <= 1'b0;
         full_c        <= 1'b0;
         full_op       <= 1'b0;
         o_core_valid  <= 1'b0;
         o_core_a      <= '0;
         o_core_b      <= '0;
         o_core_c      <= '0;
         o_core_op     <= '0;
         o_core_last   <= 1'b0;
         o_flush_done  <= 1'b0;
         o_outstanding <= 8'd0;
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
         b_last_q        <= 1'b0;
         c_last_q        <= 1'b0;
         op_last_q       <= 1'b0;
         o_last_mismatch <= 1'b0;
`endif
      end else begin
         o_core_valid <= issue;
         o_flush_done <= 1'b0;

         if (acc_a) begin
            a_q      <= i_axi4s_a_tdata;
            a_last_q <= i_axi4s_a_tlast;
            full_a   <= 1'b1;
         end
         if (acc_b) begin
            b_q    <= i_axi4s_b_tdata;
            full_b <= 1'b1;
         end
         if (acc_c) begin
            c_q    <= i_axi4s_c_tdata;
            full_c <= 1'b1;
         end
         if (acc_op) begin
            op_q    <= i_axi4s_operation_tdata;
            full_op <= 1'b1;
         end
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
         if (acc_b)  b_last_q  <= i_axi4s_b_tlast;
         if (acc_c)  c_last_q  <= i_axi4s_c_tlast;
         if (acc_op) op_last_q <= i_axi4s_operation_tlast;
         if (issue && last_diff) o_last_mismatch <= 1'b1;
`endif

         if (issue) begin
            o_core_a    <= a_q;
            o_core_b    <= b_q;
            o_core_c    <= c_q;
            o_core_op   <= op_q;
            o_core_last <= a_last_q;
            full_a      <= 1'b0;
            full_b      <= 1'b0;
            full_c      <= 1'b0;
            full_op     <= 1'b0;
         end

         unique case (1'b1)
            issue && !ret: o_outstanding <= o_outstanding + 8'd1;
            !issue && ret: o_outstanding <= o_outstanding - 8'd1;
            default:       o_outstanding <= o_outstanding;
         endcase

         unique case (state_q)
            RUN: begin
               if (i_flush) begin
                  state_q <= DRAIN;
                  full_a  <= 1'b0;
                  full_b  <= 1'b0;
                  full_c  <= 1'b0;
                  full_op <= 1'b0;
               end
            end
            DRAIN: begin
               if (o_outstanding == 8'd0) begin
                  state_q      <= DONE;
                  o_flush_done <= 1'b1;
               end
            end
            DONE:    state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_ipsxe_floating_point_abcop_sched_v1_0.sv
// Directed bench for the a/b/c/op scheduler, built with CREDITS=4.
module tb_ipsxe_floating_point_abcop_sched_v1_0;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_v, b_v, c_v, op_v;
   logic [31:0] a_d, b_d, c_d;
   logic [7:0]  op_d;
   logic        a_l, b_l, c_l, op_l;
   logic        a_r, b_r, c_r, op_r;
   logic        core_valid;
   logic [31:0] core_a, core_b, core_c;
   logic [7:0]  core_op;
   logic        core_last;
   logic        cret, flush, flush_done;
   logic [7:0]  outst;
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
   logic        mism;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ipsxe_floating_point_abcop_sched_v1_0 #(
      .DATA_WIDTH(32), .OP_WIDTH(8), .CREDITS(4)
   ) dut (
      .i_aclk(clk), .i_areset(rst),
      .i_axi4s_a_tvalid(a_v), .i_axi4s_a_tdata(a_d),
      .i_axi4s_a_tlast(a_l), .o_axi4s_a_tready(a_r),
      .i_axi4s_b_tvalid(b_v), .i_axi4s_b_tdata(b_d),
      .i_axi4s_b_tlast(b_l), .o_axi4s_b_tready(b_r),
      .i_axi4s_c_tvalid(c_v), .i_axi4s_c_tdata(c_d),
      .i_axi4s_c_tlast(c_l), .o_axi4s_c_tready(c_r),
      .i_axi4s_operation_tvalid(op_v), .i_axi4s_operation_tdata(op_d),
      .i_axi4s_operation_tlast(op_l), .o_axi4s_operation_tready(op_r),
      .o_core_valid(core_valid), .o_core_a(core_a), .o_core_b(core_b),
      .o_core_c(core_c), .o_core_op(core_op), .o_core_last(core_last),
      .i_credit_return(cret), .i_flush(flush),
      .o_flush_done(flush_done), .o_outstanding(outst)
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
      , .o_last_mismatch(mism)
`endif
   );

   typedef struct {
      logic [31:0] a, b, c;
      logic [7:0]  op;
      logic        last;
      logic [31:0] e_a, e_b, e_c;
      logic [7:0]  e_op;
      logic        e_last;
      logic [7:0]  e_out;
   } vec_t;

   vec_t vecs[4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_valid(logic va, logic vb, logic vc, logic vo);
      a_v = va; b_v = vb; c_v = vc; op_v = vo;
   endtask

   task automatic load_all();
      set_valid(1, 1, 1, 1);
      tick();
      set_valid(0, 0, 0, 0);
   endtask

   task automatic ret_n(int n);
      cret = 1'b1;
      repeat (n) tick();
      cret = 1'b0;
   endtask

   int          n_iss, prev_pos;
   logic [31:0] exp_held;

   initial begin
      vecs[0] = '{32'h3f800000, 32'h40000000, 32'h40400000, 8'h01, 1'b1,
                  32'h3f800000, 32'h40000000, 32'h40400000, 8'h01, 1'b1, 8'd1};
      vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 1'b0,
                  32'h00000000, 32'h00000000, 32'h00000000, 8'h00, 1'b0, 8'd1};
      vecs[2] = '{32'hffffffff, 32'h7f800000, 32'h80000001, 8'hff, 1'b1,
                  32'hffffffff, 32'h7f800000, 32'h80000001, 8'hff, 1'b1, 8'd1};
      vecs[3] = '{32'hdeadbeef, 32'h12345678, 32'ha5a5a5a5, 8'h5a, 1'b0,
                  32'hdeadbeef, 32'h12345678, 32'ha5a5a5a5, 8'h5a, 1'b0, 8'd1};

      rst = 1'b1; cret = 0; flush = 0;
      set_valid(1, 1, 1, 1);
      a_d = 32'h11; b_d = 32'h22; c_d = 32'h33; op_d = 8'h44;
      a_l = 0; b_l = 0; c_l = 0; op_l = 0;
      tick();
      tick();
      chk("rst_a_ready", a_r, 0);
      chk("rst_op_ready", op_r, 0);
      chk("rst_valid", core_valid, 0);
      chk("rst_core_a", core_a, 0);
      chk("rst_outst", outst, 0);
      chk("rst_flush_done", flush_done, 0);
      set_valid(0, 0, 0, 0);
      rst = 1'b0;
      tick();
      chk("run_ready", {a_r, b_r, c_r, op_r}, 4'hf);

      ret_n(1);
      chk("ret_sat0", outst, 0);

      foreach (vecs[i]) begin
         a_d = vecs[i].a; b_d = vecs[i].b; c_d = vecs[i].c;
         op_d = vecs[i].op; a_l = vecs[i].last;
         load_all();
         chk("vec_no_early", core_valid, 0);
         tick();
         chk("vec_valid", core_valid, 1);
         chk("vec_a", core_a, vecs[i].e_a);
         chk("vec_b", core_b, vecs[i].e_b);
         chk("vec_c", core_c, vecs[i].e_c);
         chk("vec_op", core_op, vecs[i].e_op);
         chk("vec_last", core_last, vecs[i].e_last);
         chk("vec_outst", outst, vecs[i].e_out);
         ret_n(1);
         chk("vec_pulse", core_valid, 0);
         chk("vec_hold_a", core_a, vecs[i].e_a);
         chk("vec_ret", outst, 0);
      end

      // staggered arrival: a@0 b@3 c@5 op@7
      a_d = 32'haaaa; b_d = 32'hbbbb; c_d = 32'hcccc; op_d = 8'h0d;
      for (int cyc = 0; cyc < 8; cyc++) begin
         set_valid(cyc == 0, cyc == 3, cyc == 5, cyc == 7);
         tick();
         set_valid(0, 0, 0, 0);
         chk("stag_no_valid", core_valid, 0);
         chk("stag_a_ready", a_r, 0);
      end
      tick();
      chk("stag_valid", core_valid, 1);
      chk("stag_c", core_c, 32'hcccc);
      chk("stag_outst", outst, 1);
      tick();
      chk("stag_pulse", core_valid, 0);
      ret_n(1);

      // back-to-back to credit exhaustion
      n_iss = 0; prev_pos = 0; exp_held = 0;
      for (int i = 0; i < 20; i++) begin
         set_valid(1, 1, 1, 1);
         a_d = 32'h100 + i; b_d = 32'h200 + i;
         c_d = 32'h300 + i; op_d = 8'(i);
         if (a_r) exp_held = 32'h100 + i;
         tick();
         if (core_valid) begin
            if (n_iss > 0) chk("b2b_spacing", i - prev_pos, 2);
            prev_pos = i;
            n_iss++;
         end
      end
      set_valid(0, 0, 0, 0);
      chk("b2b_issues", n_iss, 4);
      chk("b2b_outst", outst, 4);
      chk("b2b_ready", {a_r, b_r, c_r, op_r}, 4'h0);
      chk("b2b_held", exp_held, 32'h108);

      ret_n(1);
      chk("rec_outst3", outst, 3);
      chk("rec_no_valid", core_valid, 0);
      tick();
      chk("rec_valid", core_valid, 1);
      chk("rec_a", core_a, exp_held);
      chk("rec_b", core_b, 32'h208);
      chk("rec_outst4", outst, 4);

      // issue and return in the same cycle
      ret_n(2);
      chk("sim_pre", outst, 2);
      load_all();
      cret = 1'b1;
      tick();
      cret = 1'b0;
      chk("sim_valid", core_valid, 1);
      chk("sim_outst", outst, 2);
      tick();
      chk("sim_pulse", core_valid, 0);

      // flush collides with an issue condition
      load_all();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fcol_no_issue", core_valid, 0);
      chk("fcol_outst", outst, 2);
      chk("fcol_ready", {a_r, b_r, c_r, op_r}, 4'h0);
      ret_n(2);
      chk("fcol_not_done", flush_done, 0);
      tick();
      chk("fcol_done", flush_done, 1);
      chk("fcol_done_ready", a_r, 0);
      tick();
      chk("fcol_done_pulse", flush_done, 0);
      chk("fcol_cleared", {a_r, b_r, c_r, op_r}, 4'hf);

      // flush with three outstanding and a/b held
      repeat (3) begin
         load_all();
         tick();
      end
      chk("fl_outst", outst, 3);
      set_valid(1, 1, 0, 0);
      tick();
      set_valid(0, 0, 0, 0);
      chk("fl_held", {a_r, b_r, c_r, op_r}, 4'h3);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fl_drain_ready", {a_r, b_r, c_r, op_r}, 4'h0);
      for (int k = 0; k < 3; k++) begin
         ret_n(1);
         chk("fl_drain_ready_k", {a_r, b_r, c_r, op_r}, 4'h0);
         chk("fl_drain_nodone", flush_done, 0);
      end
      chk("fl_zero", outst, 0);
      tick();
      chk("fl_done", flush_done, 1);
      tick();
      chk("fl_done_pulse", flush_done, 0);
      chk("fl_run_ready", {a_r, b_r, c_r, op_r}, 4'hf);
      set_valid(0, 0, 1, 1);
      tick();
      set_valid(0, 0, 0, 0);
      tick();
      chk("fl_discarded", core_valid, 0);

      // reset in the middle of a drain
      set_valid(1, 1, 0, 0);
      tick();
      set_valid(0, 0, 0, 0);
      tick();
      chk("rd_issue", outst, 1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      chk("rd_draining", a_r, 0);
      rst = 1'b1;
      tick();
      chk("rd_outst", outst, 0);
      rst = 1'b0;
      tick();
      chk("rd_run_ready", a_r, 1);
      chk("rd_no_done", flush_done, 0);

      // tlast handling
      a_l = 1; b_l = 0; c_l = 1; op_l = 1;
      load_all();
      tick();
      chk("tl_last_a", core_last, 1);
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
      chk("tl_mism_set", mism, 1);
`endif
      a_l = 0; b_l = 0; c_l = 0; op_l = 0;
      load_all();
      tick();
      chk("tl_last_a0", core_last, 0);
`ifdef IPSXE_FLT_ABCOP_SCHED_LAST_CHECK_EN
      chk("tl_mism_sticky", mism, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("tl_mism_clr", mism, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
